// File: rtl/round_controller_if.sv
// Player/timer-facing signal bundle for round_controller.
// master is the controller side; slave is the player/timer environment.
interface round_controller_if #(
   parameter int SCORE_W = 8
);
   logic               start;
   logic               submit;
   logic [4:0]         guess;
   logic [4:0]         timeleft;
   logic               end_f;
   logic               set_f;
   logic [4:0]         set_v;
   logic [4:0]         target;
   logic [SCORE_W-1:0] score;
   logic [1:0]         lives;
   logic               round_win;
   logic               round_lose;
   logic               game_over;

   modport master (
      input  start, submit, guess, timeleft, end_f,
      output set_f, set_v, target, score, lives, round_win, round_lose, game_over
   );

   modport slave (
      output start, submit, guess, timeleft, end_f,
      input  set_f, set_v, target, score, lives, round_win, round_lose, game_over
   );
endinterface

// File: rtl/round_controller.sv
// Round sequencer for the binary number game: loads the seconds timer, draws targets, keeps score/lives.
// Optional macro TIME_BONUS_EN: a win scores timeleft+1 instead of 1.
module round_controller #(
   parameter int ROUND_TIME = 10,
   parameter int MIN_TIME   = 3,
   parameter int LIVES      = 3,
   parameter int SCORE_W    = 8
) (
   input logic               clk,
   input logic               rst,
   round_controller_if.master bus
);

   typedef enum logic [2:0] {IDLE, LOAD, PLAY, RESULT, OVER} state_t;

   localparam logic [4:0]       ROUND_T = 5'(ROUND_TIME);
   localparam logic [4:0]       MIN_T   = 5'(MIN_TIME);
   localparam logic [1:0]       LIVES_I = 2'(LIVES);
   localparam logic [SCORE_W:0] ONE     = (SCORE_W+1)'(1);

   state_t             state, state_n;
   logic [7:0]         lfsr, lfsr_n;
   logic [4:0]         cur_t, cur_t_n;
   logic [4:0]         target, target_n;
   logic [4:0]         set_v, set_v_n;
   logic [4:0]         draw;
   logic [SCORE_W-1:0] score, score_n, score_sat;
   logic [SCORE_W:0]   score_inc, score_sum;
   logic [1:0]         lives, lives_n, lives_dec;
   logic               set_f, set_f_n;
   logic               win, win_n, lose, lose_n;

   // A zero draw is bumped to 1 so the target is always enterable.
   assign draw = (lfsr[4:0] == 5'd0) ? 5'd1 : lfsr[4:0];

`ifdef TIME_BONUS_EN
   assign score_inc = (SCORE_W+1)'(bus.timeleft) + ONE;
`else
   assign score_inc = ONE;
`endif

   // One extra bit catches overflow so the score saturates instead of wrapping.
   assign score_sum = {1'b0, score} + score_inc;
   assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
   assign lives_dec = (lives != 2'd0) ? lives - 2'd1 : 2'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         lfsr   <= 8'hA5;
         cur_t  <= ROUND_T;
         target <= 5'd0;
         score  <= '0;
         lives  <= 2'd0;
         set_f  <= 1'b0;
         set_v  <= 5'd0;
         win    <= 1'b0;
         lose   <= 1'b0;
      end else begin
         state  <= state_n;
         lfsr   <= lfsr_n;
         cur_t  <= cur_t_n;
         target <= target_n;
         score  <= score_n;
         lives  <= lives_n;
         set_f  <= set_f_n;
         set_v  <= set_v_n;
         win    <= win_n;
         lose   <= lose_n;
      end
   end

   // The timer strobe is registered on entry to LOAD, so it is high exactly for the LOAD cycle.
   always_comb begin
      state_n  = state;
      lfsr_n   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      cur_t_n  = cur_t;
      target_n = target;
      score_n  = score;
      lives_n  = lives;
      set_f_n  = 1'b0;
      set_v_n  = set_v;
      win_n    = 1'b0;
      lose_n   = 1'b0;
      case (state)
         IDLE, OVER: begin
            if (bus.start) begin
               state_n  = LOAD;
               score_n  = '0;
               lives_n  = LIVES_I;
               cur_t_n  = ROUND_T;
               target_n = draw;
               set_f_n  = 1'b1;
               set_v_n  = ROUND_T;
            end
         end
         LOAD: state_n = PLAY;
         PLAY: begin
            if (bus.end_f) begin
               state_n = RESULT;
               lose_n  = 1'b1;
               lives_n = lives_dec;
            end else if (bus.submit && (bus.guess == target)) begin
               state_n = RESULT;
               win_n   = 1'b1;
               score_n = score_sat;
               cur_t_n = (cur_t > MIN_T) ? cur_t - 5'd1 : MIN_T;
            end else if (bus.submit) begin
               state_n = RESULT;
               lose_n  = 1'b1;
               lives_n = lives_dec;
            end
         end
         RESULT: begin
            if (lives == 2'd0) begin
               state_n = OVER;
            end else begin
               state_n  = LOAD;
               target_n = draw;
               set_f_n  = 1'b1;
               set_v_n  = cur_t;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.set_f      = set_f;
   assign bus.set_v      = set_v;
   assign bus.target     = target;
   assign bus.score      = score;
   assign bus.lives      = lives;
   assign bus.round_win  = win;
   assign bus.round_lose = lose;
   assign bus.game_over  = (state == OVER);

endmodule

// File: tb/tb_round_controller.sv
// Scoreboard bench for round_controller: expected round outcomes are queued at stimulus time
// and compared when the result pulse appears; a reference LFSR predicts each drawn target.
module tb_round_controller;

   localparam int SW = 8;

   typedef struct {
      logic win;
      logic lose;
      int   score;
      int   lives;
      logic over;
      int   set_v;
   } exp_t;

   logic       clk;
   logic       rst;
   exp_t       exp_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   int         m_score  = 0;
   int         m_lives  = 0;
   int         m_cur_t  = 10;
   logic [7:0] m_lfsr;
   logic [4:0] m_draw;

   round_controller_if #(.SCORE_W(SW)) bus ();

   round_controller #(
      .ROUND_TIME(10),
      .MIN_TIME(3),
      .LIVES(3),
      .SCORE_W(SW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference LFSR; m_draw holds the target a draw on the latest edge would produce.
   always @(posedge clk) begin
      if (rst) begin
         m_lfsr <= 8'hA5;
      end else begin
         m_draw <= (m_lfsr[4:0] == 5'd0) ? 5'd1 : m_lfsr[4:0];
         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got === expv) n_pass++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, expv);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkReset(input string p);
      checkOutput({p, "_set_f"}, 32'(bus.set_f), 0);
      checkOutput({p, "_set_v"}, 32'(bus.set_v), 0);
      checkOutput({p, "_target"}, 32'(bus.target), 0);
      checkOutput({p, "_score"}, 32'(bus.score), 0);
      checkOutput({p, "_lives"}, 32'(bus.lives), 0);
      checkOutput({p, "_win"}, 32'(bus.round_win), 0);
      checkOutput({p, "_lose"}, 32'(bus.round_lose), 0);
      checkOutput({p, "_game_over"}, 32'(bus.game_over), 0);
   endtask

   task automatic startGame();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      m_score = 0;
      m_lives = 3;
      m_cur_t = 10;
      checkOutput("start_set_f", 32'(bus.set_f), 1);
      checkOutput("start_set_v", 32'(bus.set_v), 10);
      checkOutput("start_target", 32'(bus.target), 32'(m_draw));
      checkOutput("start_score", 32'(bus.score), 0);
      checkOutput("start_lives", 32'(bus.lives), 3);
      checkOutput("start_game_over", 32'(bus.game_over), 0);
      tick();
      checkOutput("play_set_f_low", 32'(bus.set_f), 0);
   endtask

   task automatic applyStimulus(input logic do_submit, input logic correct, input logic timeout);
      exp_t e;
      int   inc;
      e.win  = 1'b0;
      e.lose = 1'b0;
      if (timeout) begin
         e.lose = 1'b1;
         if (m_lives > 0) m_lives--;
      end else if (do_submit && correct) begin
         e.win = 1'b1;
`ifdef TIME_BONUS_EN
         inc = int'(bus.timeleft) + 1;
`else
         inc = 1;
`endif
         m_score = (m_score + inc > 255) ? 255 : m_score + inc;
         if (m_cur_t > 3) m_cur_t--;
      end else if (do_submit) begin
         e.lose = 1'b1;
         if (m_lives > 0) m_lives--;
      end
      e.score = m_score;
      e.lives = m_lives;
      e.over  = (m_lives == 0);
      e.set_v = m_cur_t;
      if (e.win || e.lose) exp_q.push_back(e);
      bus.guess  = correct ? bus.target : (bus.target ^ 5'd1);
      bus.submit = do_submit;
      bus.end_f  = timeout;
      tick();
      bus.submit = 1'b0;
      bus.end_f  = 1'b0;
   endtask

   task automatic checkResult();
      exp_t e;
      int   n = 0;
      while (!(bus.round_win || bus.round_lose) && n < 8) begin
         tick();
         n++;
      end
      checkOutput("pulse_seen", 32'(bus.round_win | bus.round_lose), 1);
      checkOutput("queue_size", 32'(exp_q.size()), 1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      checkOutput("round_win", 32'(bus.round_win), 32'(e.win));
      checkOutput("round_lose", 32'(bus.round_lose), 32'(e.lose));
      checkOutput("score", 32'(bus.score), 32'(e.score));
      checkOutput("lives", 32'(bus.lives), 32'(e.lives));
      tick();
      checkOutput("win_one_cycle", 32'(bus.round_win), 0);
      checkOutput("lose_one_cycle", 32'(bus.round_lose), 0);
      if (e.over) begin
         for (int i = 0; i < 3; i++) begin
            checkOutput("over_game_over", 32'(bus.game_over), 1);
            checkOutput("over_no_set_f", 32'(bus.set_f), 0);
            tick();
         end
      end else begin
         checkOutput("reload_set_f", 32'(bus.set_f), 1);
         checkOutput("reload_set_v", 32'(bus.set_v), 32'(e.set_v));
         checkOutput("reload_target", 32'(bus.target), 32'(m_draw));
         checkOutput("target_nonzero", 32'(bus.target != 5'd0), 1);
         tick();
         checkOutput("reload_one_cycle", 32'(bus.set_f), 0);
      end
   endtask

   initial begin
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.submit   = 1'b0;
      bus.guess    = 5'd0;
      bus.timeleft = 5'd5;
      bus.end_f    = 1'b0;
      tick();
      tick();
      checkReset("reset");
      rst = 1'b0;

      // submit while idle must not produce a result
      bus.submit = 1'b1;
      tick();
      bus.submit = 1'b0;
      checkOutput("idle_submit_win", 32'(bus.round_win), 0);
      checkOutput("idle_submit_lose", 32'(bus.round_lose), 0);
      tick();

      startGame();
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkResult();
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkResult();
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkResult();

      // start during PLAY is ignored
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      checkOutput("play_start_set_f", 32'(bus.set_f), 0);
      tick();
      checkOutput("play_start_set_f2", 32'(bus.set_f), 0);

      rst = 1'b1;
      tick();
      tick();
      checkReset("midrst");
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("post_rst_set_f", 32'(bus.set_f), 0);
         checkOutput("post_rst_game_over", 32'(bus.game_over), 0);
      end

      startGame();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         checkResult();
      end

      bus.guess  = bus.target;
      bus.submit = 1'b1;
      tick();
      bus.submit = 1'b0;
      tick();
      checkOutput("over_submit_win", 32'(bus.round_win), 0);
      checkOutput("over_lives_frozen", 32'(bus.lives), 0);
      checkOutput("over_score_frozen", 32'(bus.score), 32'(m_score));

      startGame();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         checkResult();
      end
      checkOutput("floor_cur_t", 32'(bus.set_v), 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
